// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: FIFO handshake bundle; master drives wr_en/data_in/rd_en, slave returns data_out/rd_valid/count/flags/error pulses
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO over a registered RAM; ports clk, reset (async active-high), bus (slave side of sync_fifo_param_if)
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C = AE_LEVEL[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  rd_acc, wr_acc;
  always_comb begin
    rd_acc  = bus.rd_en & ~bus.empty;
    wr_acc  = bus.wr_en & (~bus.full | rd_acc);
    cnt_nxt = bus.count + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      bus.data_out     <= '0;
      bus.rd_valid     <= 1'b0;
      bus.count        <= '0;
      bus.empty        <= 1'b1;
      bus.full         <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.almost_full  <= AF_C == '0;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) begin
        rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
        bus.data_out <= mem[rd_ptr];
      end
      bus.rd_valid     <= rd_acc;
      bus.count        <= cnt_nxt;
      bus.empty        <= cnt_nxt == '0;
      bus.full         <= cnt_nxt == FULL_C;
      bus.almost_empty <= cnt_nxt <= AE_C;
      bus.almost_full  <= cnt_nxt >= AF_C;
      bus.overflow     <= bus.wr_en & bus.full & ~rd_acc;
      bus.underflow    <= bus.rd_en & bus.empty;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized scenario bench for sync_fifo_param against a queue-based reference model
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_data = 8'h00;
  logic exp_valid = 1'b0;
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
    logic was_empty, was_full, ra, wa;
    bus.wr_en = wr;
    bus.data_in = d;
    bus.rd_en = rd;
    was_empty = q.size() == 0;
    was_full = q.size() == 8;
    ra = rd && !was_empty;
    wa = wr && (!was_full || ra);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    exp_valid = ra;
    exp_ovf = wr && was_full && !ra;
    exp_udf = rd && was_empty;
    if (ra) exp_data = q.pop_front();
    if (wa) q.push_back(d);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = 8'h00;
    #2;
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", bus.almost_empty); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_errs: got ovf=%b udf=%b want 0 0", bus.overflow, bus.underflow); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'h11 + 8'(i), 1'b0);
      checks++; if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL fill_count: got %0d want %0d", bus.count, q.size()); end
      checks++; if (bus.full !== (q.size() == 8)) begin errors++; $display("FAIL fill_full: got %b want %b", bus.full, q.size() == 8); end
      checks++; if (bus.empty !== (q.size() == 0)) begin errors++; $display("FAIL fill_empty: got %b want %b", bus.empty, q.size() == 0); end
      checks++; if (bus.almost_full !== (q.size() >= 6)) begin errors++; $display("FAIL fill_almost_full: got %b want %b at count %0d", bus.almost_full, q.size() >= 6, q.size()); end
      checks++; if (bus.almost_empty !== (q.size() <= 2)) begin errors++; $display("FAIL fill_almost_empty: got %b want %b at count %0d", bus.almost_empty, q.size() <= 2, q.size()); end
    end
  endtask
  task automatic test_overflow();
    cycle(1'b1, 8'h99, 1'b0);
    checks++; if (bus.overflow !== exp_ovf) begin errors++; $display("FAIL ovf_pulse: got %b want %b", bus.overflow, exp_ovf); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", bus.count); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow); end
  endtask
  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (bus.data_out !== exp_data || bus.data_out !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_data: got %h want %h", bus.data_out, 8'h11 + 8'(i)); end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid: got %b want 1", bus.rd_valid); end
      checks++; if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL drain_count: got %0d want %0d", bus.count, q.size()); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (bus.underflow !== exp_udf) begin errors++; $display("FAIL udf_pulse: got %b want %b", bus.underflow, exp_udf); end
    checks++; if (bus.data_out !== 8'h18) begin errors++; $display("FAIL udf_data_hold: got %h want 18", bus.data_out); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL udf_rd_valid: got %b want 0", bus.rd_valid); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_one_cycle: got %b want 0", bus.underflow); end
  endtask
  task automatic test_wrap();
    logic wr, rd;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom);
      rd = 1'($urandom);
      if (q.size() == 7 && wr && !rd) wr = 1'b0;
      if (q.size() == 1 && rd && !wr) rd = 1'b0;
      cycle(wr, 8'($urandom), rd);
      checks++; if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL wrap_count: got %0d want %0d", bus.count, q.size()); end
      checks++; if (bus.rd_valid !== exp_valid) begin errors++; $display("FAIL wrap_rd_valid: got %b want %b", bus.rd_valid, exp_valid); end
      checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL wrap_data: got %h want %h", bus.data_out, exp_data); end
    end
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL wrap_flush_data: got %h want %h", bus.data_out, exp_data); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
  endtask
  task automatic test_simul_full();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL simfull_count: got %0d want 8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL simfull_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.data_out !== exp_data || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL simfull_read: got %h/%b want %h/1", bus.data_out, bus.rd_valid, exp_data); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL simfull_drain: got %h want %h", bus.data_out, exp_data); end
    end
    checks++; if (bus.data_out !== 8'hAA) begin errors++; $display("FAIL simfull_last_word: got %h want aa", bus.data_out); end
  endtask
  task automatic test_simul_empty();
    cycle(1'b1, 8'h55, 1'b1);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL simempty_count: got %0d want 1", bus.count); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL simempty_underflow: got %b want 1", bus.underflow); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL simempty_no_fallthrough: got %b want 0", bus.rd_valid); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (bus.data_out !== 8'h55 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL simempty_read: got %h/%b want 55/1", bus.data_out, bus.rd_valid); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (bus.count !== 4'd5 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got count=%0d valid=%b want 5/1", bus.count, bus.rd_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", bus.empty); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd_valid: got %b want 0", bus.rd_valid); end
    q.delete();
    exp_data = 8'h00;
    reset = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL arst_rewrite_count: got %0d want 1", bus.count); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (bus.data_out !== 8'h3C || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL arst_reread: got %h/%b want 3c/1", bus.data_out, bus.rd_valid); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
